// File: rtl/mem_stage.sv
// Memory pipeline stage: passes ALU results straight to write-back and serializes
// byte/word loads and stores to an internal RAM, stalling upstream for MEM_LAT cycles.
module mem_stage #(
  parameter int ADDR_W  = 10,
  parameter int MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [6:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_data,
  input  logic [4:0]        in_dst,
  output logic              stall,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_dst,
  output logic [31:0]       wb_data
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [6:0] OP_ADD = 7'h00;
  localparam logic [6:0] OP_SUB = 7'h01;
  localparam logic [6:0] OP_MUL = 7'h02;
  localparam logic [6:0] OP_LDB = 7'h10;
  localparam logic [6:0] OP_LDW = 7'h11;
  localparam logic [6:0] OP_STB = 7'h12;
  localparam logic [6:0] OP_STW = 7'h13;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_count;
  logic [6:0]          r_op;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_data;
  logic [4:0]          r_dst;
  logic [31:0]         r_mem [DEPTH];

  logic [ADDR_W-3:0]   w_idx;
  logic [1:0]          w_lane;
  logic [31:0]         w_rdWord;
  logic [7:0]          w_rdByte;
  logic [31:0]         w_loadData;
  logic [31:0]         w_wrWord;
  logic                w_isLoad;
  logic                w_done;
  logic                w_memWe;

  assign stall    = (r_state == ACCESS);
  assign w_idx    = r_addr[ADDR_W-1:2];
  assign w_lane   = r_addr[1:0];
  assign w_rdWord = r_mem[w_idx];
  assign w_isLoad = (r_op == OP_LDB) || (r_op == OP_LDW);
  assign w_done   = (r_state == ACCESS) && (r_count == '0);
  assign w_memWe  = w_done && !w_isLoad;

  // Lane extraction for loads and read-modify-write merge for byte stores.
  always_comb begin
    w_rdByte = w_rdWord[7:0];
    w_wrWord = w_rdWord;
    case (w_lane)
      2'd0: begin w_rdByte = w_rdWord[7:0];   w_wrWord[7:0]   = r_data[7:0]; end
      2'd1: begin w_rdByte = w_rdWord[15:8];  w_wrWord[15:8]  = r_data[7:0]; end
      2'd2: begin w_rdByte = w_rdWord[23:16]; w_wrWord[23:16] = r_data[7:0]; end
      default: begin w_rdByte = w_rdWord[31:24]; w_wrWord[31:24] = r_data[7:0]; end
    endcase
    if (r_op == OP_STW) w_wrWord = r_data;
    w_loadData = (r_op == OP_LDB) ? {24'h0, w_rdByte} : w_rdWord;
  end

  // RAM contents survive reset; an aborted store never reaches here because reset forces IDLE.
  always_ff @(posedge clk) begin
    if (w_memWe) r_mem[w_idx] <= w_wrWord;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_op     <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_dst    <= '0;
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_dst   <= '0;
      wb_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!in_valid) begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
          end else begin
            case (in_op)
              OP_ADD, OP_SUB, OP_MUL: begin
                wb_valid <= 1'b1;
                wb_we    <= (in_dst != 5'd0);
                wb_dst   <= in_dst;
                wb_data  <= in_data;
              end
              OP_LDB, OP_LDW, OP_STB, OP_STW: begin
                r_op     <= in_op;
                r_addr   <= in_addr;
                r_data   <= in_data;
                r_dst    <= in_dst;
                r_count  <= CNT_W'(MEM_LAT - 1);
                r_state  <= ACCESS;
                wb_valid <= 1'b0;
                wb_we    <= 1'b0;
              end
              default: begin
                wb_valid <= 1'b1;
                wb_we    <= 1'b0;
              end
            endcase
          end
        end
        ACCESS: begin
          if (r_count != '0) begin
            r_count <= r_count - 1'b1;
          end else begin
            r_state  <= IDLE;
            wb_valid <= 1'b1;
            wb_dst   <= r_dst;
            if (w_isLoad) begin
              wb_we   <= (r_dst != 5'd0);
              wb_data <= w_loadData;
            end else begin
              wb_we   <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against an array-based memory model.
module tb_mem_stage;

  localparam int ADDR_W  = 10;
  localparam int MEM_LAT = 4;
  localparam int WORDS   = 2 ** (ADDR_W - 2);

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [6:0]        in_op;
  logic [ADDR_W-1:0] in_addr;
  logic [31:0]       in_data;
  logic [4:0]        in_dst;
  logic              stall;
  logic              wb_valid;
  logic              wb_we;
  logic [4:0]        wb_dst;
  logic [31:0]       wb_data;

  int assertCount = 0;
  int failCount   = 0;

  logic [31:0] modelMem [WORDS];
  logic [31:0] expData;
  logic [4:0]  expDst;
  bit          dataKnown;
  bit          dstKnown;

  mem_stage #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_op(in_op), .in_addr(in_addr), .in_data(in_data), .in_dst(in_dst),
    .stall(stall), .wb_valid(wb_valid), .wb_we(wb_we), .wb_dst(wb_dst), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Presents one op while the stage is idle, walks through any access latency and checks write-back.
  task automatic applyStimulus(input logic [6:0] op, input logic [ADDR_W-1:0] addr,
                               input logic [31:0] data, input logic [4:0] dst, input bit scramble);
    bit          isMem;
    logic [31:0] word;
    int          sh;
    logic        expWe;
    in_valid = 1'b1;
    in_op    = op;
    in_addr  = addr;
    in_data  = data;
    in_dst   = dst;
    checkOutput("stall_idle", stall, 0);
    word  = modelMem[addr[ADDR_W-1:2]];
    sh    = int'(addr[1:0]) * 8;
    isMem = 1'b0;
    expWe = 1'b0;
    case (op)
      7'h00, 7'h01, 7'h02: begin
        expData = data; expDst = dst; expWe = (dst != 0); dataKnown = 1; dstKnown = 1;
      end
      7'h10: begin
        isMem = 1; expData = (word >> sh) & 32'hFF; expDst = dst; expWe = (dst != 0);
        dataKnown = 1; dstKnown = 1;
      end
      7'h11: begin
        isMem = 1; expData = word; expDst = dst; expWe = (dst != 0); dataKnown = 1; dstKnown = 1;
      end
      7'h12: begin
        isMem = 1; expDst = dst; dstKnown = 1;
        modelMem[addr[ADDR_W-1:2]] = (word & ~(32'hFF << sh)) | ((data & 32'hFF) << sh);
      end
      7'h13: begin
        isMem = 1; expDst = dst; dstKnown = 1;
        modelMem[addr[ADDR_W-1:2]] = data;
      end
      default: begin
        dataKnown = 0; dstKnown = 0;
      end
    endcase
    @(posedge clk); #1;
    if (isMem) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        checkOutput("stall_access", stall, 1);
        checkOutput("wbvalid_access", wb_valid, 0);
        if (scramble) begin
          in_valid = 1'($urandom_range(0, 1));
          in_op    = 7'($urandom);
          in_addr  = ADDR_W'($urandom);
          in_data  = $urandom;
          in_dst   = 5'($urandom);
        end
        @(posedge clk); #1;
      end
    end
    checkOutput("wb_valid", wb_valid, 1);
    checkOutput("wb_we", wb_we, 32'(expWe));
    checkOutput("stall_done", stall, 0);
    if (dstKnown)  checkOutput("wb_dst", 32'(wb_dst), 32'(expDst));
    if (dataKnown) checkOutput("wb_data", wb_data, expData);
  endtask

  task automatic idleCycle();
    in_valid = 1'b0;
    in_op    = 7'($urandom);
    @(posedge clk); #1;
    checkOutput("idle_wb_valid", wb_valid, 0);
    checkOutput("idle_wb_we", wb_we, 0);
    checkOutput("idle_stall", stall, 0);
  endtask

  initial begin
    logic [6:0] opTable [9];
    logic [6:0] op;
    opTable = '{7'h00, 7'h01, 7'h02, 7'h10, 7'h11, 7'h12, 7'h13, 7'h3F, 7'h7F};

    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_addr = '0; in_data = '0; in_dst = '0;
    dataKnown = 1; dstKnown = 1; expData = '0; expDst = '0;
    #23;
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_wb_valid", wb_valid, 0);
    checkOutput("rst_wb_we", wb_we, 0);
    checkOutput("rst_wb_dst", 32'(wb_dst), 0);
    checkOutput("rst_wb_data", wb_data, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill every RAM word so later loads have defined expectations; low address bits are junk.
    for (int w = 0; w < WORDS; w++)
      applyStimulus(7'h13, ADDR_W'((w * 4) + $urandom_range(0, 3)), $urandom, 5'($urandom), 0);
    idleCycle();

    applyStimulus(7'h00, 10'h000, 32'h1234, 5'd5, 0);
    applyStimulus(7'h00, 10'h000, 32'h5678, 5'd0, 0);
    applyStimulus(7'h13, 10'h008, 32'hDEADBEEF, 5'd1, 0);
    applyStimulus(7'h11, 10'h008, 32'h0, 5'd3, 0);
    checkOutput("ldw_deadbeef", wb_data, 32'hDEADBEEF);
    applyStimulus(7'h12, 10'h009, 32'h55, 5'd2, 0);
    applyStimulus(7'h11, 10'h008, 32'h0, 5'd4, 0);
    checkOutput("stb_merge", wb_data, 32'hDEAD55EF);
    applyStimulus(7'h10, 10'h00B, 32'h0, 5'd6, 0);
    checkOutput("ldb_lane3", wb_data, 32'h000000DE);
    applyStimulus(7'h13, 10'h020, 32'hA5A5_0F0F, 5'd7, 1);
    applyStimulus(7'h11, 10'h020, 32'h0, 5'd8, 1);
    applyStimulus(7'h3F, 10'h008, 32'hFFFF_FFFF, 5'd9, 0);
    applyStimulus(7'h7F, 10'h008, 32'h0000_0000, 5'd10, 0);
    applyStimulus(7'h11, 10'h008, 32'h0, 5'd11, 0);
    idleCycle();

    // Reset in the middle of a word store must abort it.
    in_valid = 1'b1; in_op = 7'h13; in_addr = 10'h010; in_data = 32'hCAFEF00D; in_dst = 5'd1;
    @(posedge clk); #1;
    checkOutput("abort_stall", stall, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_stall_rst", stall, 0);
    checkOutput("abort_wb_valid", wb_valid, 0);
    checkOutput("abort_wb_we", wb_we, 0);
    checkOutput("abort_wb_dst", 32'(wb_dst), 0);
    checkOutput("abort_wb_data", wb_data, 0);
    in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    expData = '0; expDst = '0; dataKnown = 1; dstKnown = 1;
    applyStimulus(7'h11, 10'h010, 32'h0, 5'd12, 0);

    for (int n = 0; n < 400; n++) begin
      op = opTable[$urandom_range(0, 8)];
      if (op == 7'h7F) op = 7'($urandom);
      applyStimulus(op, ADDR_W'($urandom), $urandom, 5'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                    1'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0) idleCycle();
    end
    idleCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
